// File: rtl/reg_file_sb.sv
// Two-read / two-write register file with a load scoreboard.
// Port W is ALU writeback, port L is load return; busy bits track outstanding loads.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] address_w,
  input  logic [DATA_W-1:0] busW,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              wr_conflict,
  output logic              sb_err
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic              w_en;
  logic              l_en;
  logic              issue_en;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [NREGS-1:0]  busy_q;

  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic              sb_err_q, sb_err_d;

  logic              same_ld_addr;
  logic              issue_err;
  logic              ret_err;
  logic              cnt_inc;
  logic              cnt_dec;

  // Enables are qualified by reset so nothing commits or bypasses in the reset cycle.
  assign w_en     = rst_n && RegWr && !(ZERO_REG && address_w == '0);
  assign l_en     = rst_n && ld_we && !(ZERO_REG && ld_addr == '0);
  assign issue_en = ld_issue && !(ZERO_REG && ld_rd == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

      logic [DATA_W-1:0] data_q, data_d;
      logic              bit_q, bit_d;
      logic              set_hit;
      logic              clr_hit;

      always_comb begin
        data_d = data_q;
        if (w_en && address_w == IDX) begin
          data_d = busW;
        end else if (l_en && ld_addr == IDX) begin
          data_d = ld_data;
        end
      end

      // A new issue owns the bit even if the older load returns in the same cycle.
      always_comb begin
        set_hit = issue_en && ld_rd == IDX;
        clr_hit = ld_we && ld_addr == IDX;
        bit_d   = set_hit | (bit_q & ~clr_hit);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_q <= '0;
          bit_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          bit_q  <= bit_d;
        end
      end

      assign rf_q[gi]   = data_q;
      assign busy_q[gi] = bit_q;
    end
  endgenerate

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_busy;

  assign rd_addr[0] = address_a;
  assign rd_addr[1] = address_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_val;

      always_comb begin
        rd_val = rf_q[rd_addr[gi]];
        if (BYPASS) begin
          if (w_en && address_w == rd_addr[gi]) begin
            rd_val = busW;
          end else if (l_en && ld_addr == rd_addr[gi]) begin
            rd_val = ld_data;
          end
        end
        if (ZERO_REG && rd_addr[gi] == '0) begin
          rd_val = '0;
        end
      end

      assign rd_data[gi] = rd_val;
      assign rd_busy[gi] = busy_q[rd_addr[gi]];
    end
  endgenerate

  assign busA   = rd_data[0];
  assign busB   = rd_data[1];
  assign busy_a = rd_busy[0];
  assign busy_b = rd_busy[1];

  // Counter moves by the net change of the busy vector, so it always equals its popcount.
  always_comb begin
    same_ld_addr  = ld_we && ld_addr == ld_rd;
    issue_err     = issue_en && busy_q[ld_rd] && !same_ld_addr;
    ret_err       = ld_we && !busy_q[ld_addr];
    cnt_inc       = issue_en && !busy_q[ld_rd];
    cnt_dec       = ld_we && busy_q[ld_addr] && !(issue_en && ld_rd == ld_addr);
    busy_cnt_d    = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    wr_conflict_d = wr_conflict_q | (RegWr && ld_we && address_w == ld_addr);
    sb_err_d      = sb_err_q | issue_err | ret_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt_q    <= '0;
      wr_conflict_q <= 1'b0;
      sb_err_q      <= 1'b0;
    end else begin
      busy_cnt_q    <= busy_cnt_d;
      wr_conflict_q <= wr_conflict_d;
      sb_err_q      <= sb_err_d;
    end
  end

  assign busy_cnt    = busy_cnt_q;
  assign wr_conflict = wr_conflict_q;
  assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Vector-table bench for reg_file_sb: each record is applied on the falling edge,
// its expected outputs queued, then popped and compared before the next rising edge.
module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address_a, address_b, address_w, ld_rd, ld_addr;
  logic [DATA_W-1:0] busA, busB, busW, ld_data;
  logic              busy_a, busy_b, RegWr, ld_issue, ld_we;
  logic [ADDR_W:0]   busy_cnt;
  logic              wr_conflict, sb_err;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .address_a(address_a), .address_b(address_b),
    .busA(busA), .busB(busB), .busy_a(busy_a), .busy_b(busy_b),
    .RegWr(RegWr), .address_w(address_w), .busW(busW),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy_cnt(busy_cnt), .wr_conflict(wr_conflict), .sb_err(sb_err)
  );

  typedef struct {
    logic        rn;
    logic [4:0]  a, b, aw, rd, la;
    logic        wr, iss, lwe;
    logic [31:0] bw, ld;
    logic [31:0] ea, eb;
    logic        eba, ebb;
    logic [5:0]  ecnt;
    logic        econf, eerr;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ea, eb;
    logic        eba, ebb;
    logic [5:0]  ecnt;
    logic        econf, eerr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input int rn, a, b, wr, aw, input logic [31:0] bw,
                              input int iss, rd, lwe, la, input logic [31:0] ld,
                              input logic [31:0] ea, eb, input int eba, ebb, ecnt, econf, eerr);
    vec_t v;
    v.rn = rn[0];  v.a = 5'(a);   v.b = 5'(b);
    v.wr = wr[0];  v.aw = 5'(aw); v.bw = bw;
    v.iss = iss[0]; v.rd = 5'(rd);
    v.lwe = lwe[0]; v.la = 5'(la); v.ld = ld;
    v.ea = ea; v.eb = eb; v.eba = eba[0]; v.ebb = ebb[0];
    v.ecnt = 6'(ecnt); v.econf = econf[0]; v.eerr = eerr[0];
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rn;  address_a = v.a; address_b = v.b;
    RegWr = v.wr;  address_w = v.aw; busW = v.bw;
    ld_issue = v.iss; ld_rd = v.rd;
    ld_we = v.lwe; ld_addr = v.la; ld_data = v.ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; address_a = '0; address_b = '0; RegWr = 1'b0; address_w = '0; busW = '0;
    ld_issue = 1'b0; ld_rd = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);

    // Preload regs 1..31; port B reads back the previous cycle's write from storage.
    for (int i = 1; i < 32; i++)
      vecs.push_back(mk(1, i, i-1, 1, i, 32'h1000+i, 0,0, 0,0,0,
                        32'h1000+i, (i == 1) ? 32'h0 : 32'h1000+i-1, 0,0, 0,0,0));
    // Make state non-trivial before reset: two busy regs, both sticky flags set.
    vecs.push_back(mk(1, 2,6,  0,0,0,          1,2, 0,0,0,           32'h1002,32'h1006, 0,0, 0,0,0));
    vecs.push_back(mk(1, 2,6,  0,0,0,          1,6, 0,0,0,           32'h1002,32'h1006, 1,0, 1,0,0));
    vecs.push_back(mk(1, 2,6,  1,10,32'hAAAA,  0,0, 1,10,32'hBBBB,  32'h1002,32'h1006, 1,1, 2,0,0));
    // T1 reset; the issue during reset must be ignored.
    vecs.push_back(mk(0, 10,6, 0,0,0,          1,5, 0,0,0,           32'hAAAA,32'h1006, 0,1, 2,1,1));
    vecs.push_back(mk(1, 10,31,0,0,0,          0,0, 0,0,0,           0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 5,3,  0,0,0,          0,0, 0,0,0,           0,0, 0,0, 0,0,0));
    // T2 write with same-cycle bypass, then stored value.
    vecs.push_back(mk(1, 5,4,  1,5,32'hDEADBEEF, 0,0, 0,0,0,         32'hDEADBEEF,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 5,0,  0,0,0,          0,0, 0,0,0,           32'hDEADBEEF,0, 0,0, 0,0,0));
    // T3 register zero.
    vecs.push_back(mk(1, 0,0,  1,0,32'h1234,   1,0, 0,0,0,           0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 0,5,  0,0,0,          0,0, 0,0,0,           0,32'hDEADBEEF, 0,0, 0,0,0));
    // T4 load issue, three cycles outstanding, return.
    vecs.push_back(mk(1, 7,7,  0,0,0,          1,7, 0,0,0,           0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 7,0,  0,0,0,          0,0, 0,0,0,           0,0, 1,0, 1,0,0));
    vecs.push_back(mk(1, 7,0,  0,0,0,          0,0, 0,0,0,           0,0, 1,0, 1,0,0));
    vecs.push_back(mk(1, 7,7,  0,0,0,          0,0, 1,7,32'hCAFE,    32'hCAFE,32'hCAFE, 1,1, 1,0,0));
    vecs.push_back(mk(1, 7,0,  0,0,0,          0,0, 0,0,0,           32'hCAFE,0, 0,0, 0,0,0));
    // T5 W/L collision on a busy reg: W data wins, conflict sticky, no scoreboard error.
    vecs.push_back(mk(1, 9,8,  0,0,0,          1,9, 0,0,0,           0,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 9,8,  1,9,32'h1,      0,0, 1,9,32'h2,       32'h1,0, 1,0, 1,0,0));
    vecs.push_back(mk(1, 9,12, 0,0,0,          1,12,0,0,0,           32'h1,0, 0,0, 0,1,0));
    vecs.push_back(mk(1, 11,12,1,11,32'h55,    0,0, 1,12,32'h66,     32'h55,32'h66, 0,1, 1,1,0));
    vecs.push_back(mk(1, 11,12,0,0,0,          0,0, 0,0,0,           32'h55,32'h66, 0,0, 0,1,0));
    // T6 scoreboard edges, including set/clear of different regs in one cycle.
    vecs.push_back(mk(1, 4,13, 0,0,0,          1,4, 0,0,0,           0,0, 0,0, 0,1,0));
    vecs.push_back(mk(1, 4,13, 0,0,0,          1,13,0,0,0,           0,0, 1,0, 1,1,0));
    vecs.push_back(mk(1, 4,13, 0,0,0,          1,4, 1,4,32'h44,      32'h44,0, 1,1, 2,1,0));
    vecs.push_back(mk(1, 4,13, 0,0,0,          1,14,1,13,32'h133,    32'h44,32'h133, 1,1, 2,1,0));
    vecs.push_back(mk(1, 4,14, 0,0,0,          0,0, 0,0,0,           32'h44,0, 1,1, 2,1,0));
    vecs.push_back(mk(1, 4,14, 0,0,0,          0,0, 1,4,32'h45,      32'h45,0, 1,1, 2,1,0));
    vecs.push_back(mk(1, 4,13, 0,0,0,          0,0, 1,4,32'h46,      32'h46,32'h133, 0,0, 1,1,0));
    vecs.push_back(mk(1, 4,14, 0,0,0,          0,0, 0,0,0,           32'h46,0, 0,1, 1,1,1));
    vecs.push_back(mk(1, 14,0, 0,0,0,          0,0, 1,14,32'h77,     32'h77,0, 1,0, 1,1,1));
    vecs.push_back(mk(1, 14,4, 0,0,0,          0,0, 0,0,0,           32'h77,32'h46, 0,0, 0,1,1));
    vecs.push_back(mk(0, 14,4, 0,0,0,          0,0, 0,0,0,           32'h77,32'h46, 0,0, 0,1,1));
    vecs.push_back(mk(1, 14,4, 0,0,0,          0,0, 0,0,0,           0,0, 0,0, 0,0,0));
    // Fill every scoreboard entry, then drain it, to exercise the counter range.
    for (int i = 1; i < 32; i++)
      vecs.push_back(mk(1, i,0, 0,0,0, 1,i, 0,0,0, 0,0, 0,0, i-1,0,0));
    vecs.push_back(mk(1, 31,1, 0,0,0, 0,0, 0,0,0, 0,0, 1,1, 31,0,0));
    for (int i = 1; i < 32; i++)
      vecs.push_back(mk(1, i,0, 0,0,0, 0,0, 1,i,i, i,0, 1,0, 32-i,0,0));
    vecs.push_back(mk(1, 31,30,0,0,0, 0,0, 0,0,0, 31,30, 0,0, 0,0,0));
    // Issue to an already-busy reg raises the error flag.
    vecs.push_back(mk(1, 3,0,  0,0,0, 1,3, 0,0,0, 3,0, 0,0, 0,0,0));
    vecs.push_back(mk(1, 3,0,  0,0,0, 1,3, 0,0,0, 3,0, 1,0, 1,0,0));
    vecs.push_back(mk(1, 3,0,  0,0,0, 0,0, 0,0,0, 3,0, 1,0, 1,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back('{i, vecs[i].ea, vecs[i].eb, vecs[i].eba, vecs[i].ebb,
                        vecs[i].ecnt, vecs[i].econf, vecs[i].eerr});
      #2;
      e = exp_q.pop_front();
      check("busA",        e.idx, busA, e.ea);
      check("busB",        e.idx, busB, e.eb);
      check("busy_a",      e.idx, 32'(busy_a), 32'(e.eba));
      check("busy_b",      e.idx, 32'(busy_b), 32'(e.ebb));
      check("busy_cnt",    e.idx, 32'(busy_cnt), 32'(e.ecnt));
      check("wr_conflict", e.idx, 32'(wr_conflict), 32'(e.econf));
      check("sb_err",      e.idx, 32'(sb_err), 32'(e.eerr));
      $display("vec %0d rst_n=%0b a=%0d b=%0d busA=%h busB=%h busy=%0b%0b cnt=%0d conf=%0b err=%0b",
               e.idx, rst_n, address_a, address_b, busA, busB, busy_a, busy_b,
               busy_cnt, wr_conflict, sb_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
